// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited imem requests,
// response buffering with redirect flush, and in-order delivery to decode.

// Generic circular FIFO with synchronous flush.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none inside; the caller must never push while full.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  output logic                         pop_vld,
  input  logic                         pop_rdy,
  output logic [WIDTH-1:0]             pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;

  assign pop_vld = (cnt != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_vld && pop_rdy;
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_vld) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// Fetch unit: issues word fetches from pc and streams {instr, pc} to decode.
// Latency: an accepted imem response appears on instr the following cycle.
// Backpressure: instr_ready stalls the FIFO; requests stop once inflight+buffered hits DEPTH.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [0:0] ST_RESET = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] pc;
  } ifq_ent_t;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_push;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] drop_after;
  logic [31:0]   redirect_tgt;

  ifq_ent_t push_ent;
  ifq_ent_t head_ent;
  logic     head_vld;

  assign credit_used    = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign imem_req_valid = (state == ST_FETCH) && (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Words still owed to a pre-redirect fetch stream are swallowed here.
  assign rsp_drop     = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_push     = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
  assign drop_after   = drop_cnt - CW'(rsp_drop);
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RESET;
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= ST_FETCH;
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        pc       <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        drop_cnt <= drop_after + inflight - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc     <= pc + 32'd4;
        if (rsp_push) rsp_pc <= rsp_pc + 32'd4;
        drop_cnt <= drop_after;
      end
    end
  end

  assign push_ent.dat = imem_rsp_data;
  assign push_ent.pc  = rsp_pc;

  sync_fifo #(
    .WIDTH ($bits(ifq_ent_t)),
    .DEPTH (DEPTH)
  ) u_ifq (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push_vld (rsp_push),
    .push_dat (push_ent),
    .pop_vld  (head_vld),
    .pop_rdy  (instr_ready),
    .pop_dat  (head_ent),
    .count    (fifo_cnt)
  );

  assign instr_valid = head_vld;
  assign instr       = head_vld ? head_ent.dat : NOP;
  assign instr_pc    = head_vld ? head_ent.pc  : 32'h0000_0000;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with configurable latency,
// expected {pc, word} queued at request acceptance and compared at instr handshake.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0013;
  endfunction

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] redir_tgt = 32'h0;
  logic [31:0] last_pc = 32'h0;
  int          m_drop = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_req = 0;
  int          n_deliv = 0;
  int          n_spurious = 0;
  bit          rdy_mem = 1'b0;
  bit          rdy_ins = 1'b0;
  bit          redir = 1'b0;
  bit          kept_prev = 1'b0;
  bit          redir_prev = 1'b0;
  bit          last_req_valid = 1'b0;

  task automatic step();
    logic        rv;
    logic [31:0] rd;
    logic        kept;
    logic [63:0] e;
    @(negedge clk);
    cyc++;
    imem_req_ready = rdy_mem;
    instr_ready    = rdy_ins;
    redirect_valid = redir;
    redirect_pc    = redir_tgt;
    rv = 1'b0;
    rd = 32'hDEAD_BEEF;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rv = 1'b1;
      rd = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    #1;
    check("req_addr", imem_req_addr, m_pc);
    if (redir)      check("req_valid_in_redirect", {31'b0, imem_req_valid}, 32'd0);
    if (kept_prev)  check("rsp_to_instr_latency", {31'b0, instr_valid}, 32'd1);
    if (redir_prev) check("flush_after_redirect", {31'b0, instr_valid}, 32'd0);
    if (!instr_valid) begin
      check("instr_nop_idle", instr, NOP);
      check("instr_pc_idle", instr_pc, 32'h0);
    end
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) n_spurious++;
      else begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e[63:32]);
        check("instr", instr, e[31:0]);
        n_deliv++;
        last_pc = instr_pc;
      end
    end
    kept = rv && (m_drop == 0) && !redir;
    if (rv && m_drop > 0) m_drop--;
    if (redir) begin
      exp_q.delete();
      m_pc = {redir_tgt[31:2], 2'b00};
      m_drop += mq_addr.size();
    end else if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(m_pc);
      mq_due.push_back(cyc + lat);
      exp_q.push_back({m_pc, mem_word(m_pc)});
      req_log.push_back(m_pc);
      m_pc += 32'd4;
      n_req++;
    end
    kept_prev      = kept;
    redir_prev     = redir;
    last_req_valid = imem_req_valid;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redir = 1'b1;
    redir_tgt = tgt;
    step();
    redir = 1'b0;
  endtask

  task automatic drain();
    rdy_mem = 1'b0;
    rdy_ins = 1'b1;
    repeat (8) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_first_delivery(input string tag, input logic [31:0] exp_pc);
    int d0;
    d0 = n_deliv;
    for (int i = 0; i < 30 && n_deliv == d0; i++) step();
    check({tag, "_delivered"}, {31'b0, n_deliv > d0}, 32'd1);
    check({tag, "_first_pc"}, last_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    int r0;
    int d0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("req_valid_before_fetch", {31'b0, imem_req_valid}, 32'd0);

    // Streaming from the wrapping reset PC with 1-cycle memory.
    rdy_mem = 1'b1;
    rdy_ins = 1'b1;
    lat = 1;
    repeat (30) step();
    check("wrap_req0", req_log[0], 32'hFFFF_FFF8);
    check("wrap_req1", req_log[1], 32'hFFFF_FFFC);
    check("wrap_req2", req_log[2], 32'h0000_0000);
    check("stream_rate", {31'b0, n_deliv >= 16}, 32'd1);

    // Consumer stall: credits cap outstanding+buffered at DEPTH.
    drain();
    do_redirect(32'h0000_0000);
    rdy_mem = 1'b1;
    rdy_ins = 1'b0;
    n0 = n_req;
    repeat (10) step();
    check("stall_req_count", 32'(n_req - n0), 32'(DEPTH));
    check("stall_req_valid", {31'b0, last_req_valid}, 32'd0);
    rdy_ins = 1'b1;
    d0 = n_deliv;
    repeat (8) step();
    check("stall_resume_deliv", {31'b0, (n_deliv - d0) >= 2}, 32'd1);
    check("stall_resume_addr", req_log[n0 + 2], 32'h0000_0008);

    // Redirect with two fetches in flight on 3-cycle memory.
    drain();
    lat = 3;
    do_redirect(32'h0000_0040);
    rdy_mem = 1'b1;
    for (int i = 0; i < 20 && mq_addr.size() < 2; i++) step();
    check("inflight_two", 32'(mq_addr.size()), 32'd2);
    r0 = req_log.size();
    do_redirect(32'h0000_0102);
    wait_first_delivery("redir_102", 32'h0000_0100);
    check("redir_102_req", req_log[r0], 32'h0000_0100);

    // Redirect coinciding with a response while another is still pending.
    for (int i = 0; i < 40 && !(mq_addr.size() == 2 && mq_due[0] == cyc + 1); i++) step();
    check("rsp_redirect_setup", 32'(mq_addr.size()), 32'd2);
    r0 = req_log.size();
    do_redirect(32'h0000_0200);
    wait_first_delivery("redir_200", 32'h0000_0200);
    check("redir_200_req", req_log[r0], 32'h0000_0200);
    repeat (10) step();

    // Asynchronous reset mid-operation with the queue backed up.
    rdy_ins = 1'b0;
    lat = 2;
    repeat (6) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mq_addr.delete();
    mq_due.delete();
    exp_q.delete();
    m_pc = RESET_PC;
    m_drop = 0;
    kept_prev = 1'b0;
    redir_prev = 1'b0;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
    r0 = req_log.size();
    rdy_ins = 1'b1;
    repeat (12) step();
    check("post_reset_req_addr", req_log[r0], RESET_PC);
    check("post_reset_req_addr1", req_log[r0 + 1], RESET_PC + 32'd4);

    check("spurious_instr", 32'(n_spurious), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
